tuser_out_merge: RTL

//  Parametrised successor of the egress tuple/AXIS merge stage. Buffers metadata tuples from the

---
 rtl/tout_pkg.sv | 24 ++
 rtl/tout_tuple_fifo.sv | 61 ++++++
 rtl/tuser_out_merge.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/tout_pkg.sv
// ----------------------------------------------------------------------------
// Package: tout_pkg
// Purpose: Shared definitions for the egress tuple/AXIS merge stage.
//          Holds the FSM state encoding and default parameter values used by
//          tuser_out_merge and tout_tuple_fifo.
// Contents:
//   state_t        2-bit FSM encoding (ST_IDLE = 00, ST_BODY = 01)
//   DEF_DATA_W     default AXIS data width
//   DEF_TUPLE_W    default tuple / tuser width
//   DEF_TQ_DEPTH   default tuple FIFO depth
// ----------------------------------------------------------------------------
package tout_pkg;

    localparam int DEF_DATA_W   = 256;
    localparam int DEF_TUPLE_W  = 128;
    localparam int DEF_TQ_DEPTH = 4;

    // Codes 2'b10 and 2'b11 are never entered; the FSM recovers them to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BODY = 2'b01
    } state_t;

endpackage

// File: rtl/tout_tuple_fifo.sv
// ----------------------------------------------------------------------------
// Module: tout_tuple_fifo
// Purpose: Synchronous FIFO holding metadata tuples, WIDTH x DEPTH.
//          Pointers carry one extra wrap bit so full and empty are told
//          apart without a separate occupancy counter. Read data is the
//          head entry, available combinationally; a word written on a clock
//          edge becomes visible on the following cycle.
// Ports:
//   clk    in   clock
//   rst    in   synchronous active-high reset (empties the FIFO)
//   wr_en  in   write strobe (caller guarantees space, or a same-cycle pop)
//   din    in   WIDTH write data
//   rd_en  in   pop strobe (caller guarantees not empty)
//   dout   out  WIDTH head entry
//   full   out  FIFO holds DEPTH entries
//   empty  out  FIFO holds no entries
// ----------------------------------------------------------------------------
module tout_tuple_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;

    // NOTE: sequential state is always updated with non-blocking (<=) so every
    // flop samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers alone
    // decide which entries are valid, so clearing it would only cost logic.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[PW-1:0]] <= din;
    end

    assign dout  = mem[rd_ptr[PW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                   (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

endmodule

// File: rtl/tuser_out_merge.sv
// ----------------------------------------------------------------------------
// Module: tuser_out_merge
// Purpose: Egress tuple/AXIS merge stage. Buffers deparser tuples in a FIFO
//          and attaches one tuple to each outgoing AXI4-Stream packet on
//          tout_btuser. A packet is held off (tout_aready=0) until its tuple
//          is available, so data never leaves without metadata.
// Configuration macro:
//   TUSER_ALL_BEATS_EN  defined: the tuple is driven on every beat of the
//                       packet. Undefined (default): tuple on the first beat
//                       only, zero on later beats.
// Ports:
//   tout_aclk / tout_arst          clock / synchronous active-high reset
//   tout_avalid/aready/adata/akeep/atlast   input AXIS stream
//   tout_valid / tout_data         tuple write strobe / tuple value
//   tout_tready                    tuple FIFO not full
//   tout_bvalid/bready/bdata/bkeep/btlast/btuser   output AXIS stream
//   tout_ovf                       sticky: tuple dropped on a full FIFO
//   dbg_state                      FSM state
// ----------------------------------------------------------------------------
module tuser_out_merge
    import tout_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int TUPLE_W  = DEF_TUPLE_W,
    parameter int TQ_DEPTH = DEF_TQ_DEPTH
) (
    input  logic                  tout_aclk,
    input  logic                  tout_arst,
    input  logic                  tout_avalid,
    output logic                  tout_aready,
    input  logic [DATA_W-1:0]     tout_adata,
    input  logic [DATA_W/8-1:0]   tout_akeep,
    input  logic                  tout_atlast,
    input  logic                  tout_valid,
    input  logic [TUPLE_W-1:0]    tout_data,
    output logic                  tout_tready,
    output logic                  tout_bvalid,
    input  logic                  tout_bready,
    output logic [DATA_W-1:0]     tout_bdata,
    output logic [DATA_W/8-1:0]   tout_bkeep,
    output logic                  tout_btlast,
    output logic [TUPLE_W-1:0]    tout_btuser,
    output logic                  tout_ovf,
    output logic [1:0]            dbg_state
);

    state_t               state;
    state_t               state_nx;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [TUPLE_W-1:0]   fifo_head;
    logic                 push;
    logic                 pop;
    logic                 out_free;
    logic                 accept;
    logic [TUPLE_W-1:0]   body_tuser;

    // Output register can take a new beat when empty or draining this cycle.
    assign out_free = ~tout_bvalid | tout_bready;
    assign accept   = tout_avalid & tout_aready;

    // A push on a full FIFO is still accepted when a pop frees a slot the
    // same cycle; only an unmatched push on full is a drop.
    assign push = tout_valid & (~fifo_full | pop);

    tout_tuple_fifo #(
        .WIDTH (TUPLE_W),
        .DEPTH (TQ_DEPTH)
    ) u_fifo (
        .clk   (tout_aclk),
        .rst   (tout_arst),
        .wr_en (push),
        .din   (tout_data),
        .rd_en (pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // FSM state register
    always_ff @(posedge tout_aclk) begin
        if (tout_arst) state <= ST_IDLE;
        else           state <= state_nx;
    end

    // FSM next-state logic
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (accept && !tout_atlast) state_nx = ST_BODY;
            ST_BODY: if (accept &&  tout_atlast) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // FSM outputs: ready gating and the tuple pop on a packet's first beat
    always_comb begin
        tout_aready = 1'b0;
        pop         = 1'b0;
        case (state)
            ST_IDLE: begin
                tout_aready = out_free & ~fifo_empty;
                pop         = tout_avalid & out_free & ~fifo_empty;
            end
            ST_BODY: tout_aready = out_free;
            default: tout_aready = 1'b0;
        endcase
    end

`ifdef TUSER_ALL_BEATS_EN
    // Popped tuple is kept for the remaining beats of the packet.
    logic [TUPLE_W-1:0] tuple_hold;

    always_ff @(posedge tout_aclk) begin
        if (tout_arst) tuple_hold <= '0;
        else if (pop)  tuple_hold <= fifo_head;
    end

    assign body_tuser = tuple_hold;
`else
    assign body_tuser = '0;
`endif

    // Output register: loads on an accepted beat, clears valid once drained,
    // and otherwise holds every field stable under backpressure.
    always_ff @(posedge tout_aclk) begin
        if (tout_arst) begin
            tout_bvalid <= 1'b0;
            tout_bdata  <= '0;
            tout_bkeep  <= '0;
            tout_btlast <= 1'b0;
            tout_btuser <= '0;
        end else if (accept) begin
            tout_bvalid <= 1'b1;
            tout_bdata  <= tout_adata;
            tout_bkeep  <= tout_akeep;
            tout_btlast <= tout_atlast;
            tout_btuser <= (state == ST_IDLE) ? fifo_head : body_tuser;
        end else if (tout_bready) begin
            tout_bvalid <= 1'b0;
        end
    end

    // Sticky overflow: a tuple arrived with no room and no same-cycle pop.
    always_ff @(posedge tout_aclk) begin
        if (tout_arst)                              tout_ovf <= 1'b0;
        else if (tout_valid && fifo_full && !pop)   tout_ovf <= 1'b1;
    end

    assign tout_tready = ~fifo_full;
    assign dbg_state   = state;

endmodule
